// File: rtl/mem_fifo_arbiter.sv
// Round-robin arbiter and credit scheduler that shares the write port of a 3-entry click FIFO
// between clocked requesters using 2-phase toggle handshakes.
module mem_fifo_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DEPTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             i_req,
  output logic [N_REQ-1:0]             o_grant,
  output logic [$clog2(N_REQ)-1:0]     o_gnt_id,
  output logic [N_REQ-1:0]             o_ack,
  output logic                         o_drive,
  input  logic                         i_free,
  input  logic                         i_drain,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [15:0]   TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [IW-1:0] PTR_RST   = IW'(N_REQ-1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR
  } state_t;

  state_t state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [IW-1:0]    gnt_id_q, gnt_id_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             drive_q, drive_d;
  logic [CW-1:0]    count_q, count_d;
  logic [15:0]      timer_q, timer_d;

  logic [SYNC_STAGES-1:0] free_sync_q, drain_sync_q;
  logic                   free_prev_q, drain_prev_q;
  logic                   free_ev, drain_ev;

  // Each toggle on the async inputs becomes exactly one single-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_sync_q  <= '0;
      drain_sync_q <= '0;
      free_prev_q  <= 1'b0;
      drain_prev_q <= 1'b0;
    end else begin
      free_sync_q  <= {free_sync_q[SYNC_STAGES-2:0], i_free};
      drain_sync_q <= {drain_sync_q[SYNC_STAGES-2:0], i_drain};
      free_prev_q  <= free_sync_q[SYNC_STAGES-1];
      drain_prev_q <= drain_sync_q[SYNC_STAGES-1];
    end
  end

  assign free_ev  = free_sync_q[SYNC_STAGES-1] ^ free_prev_q;
  assign drain_ev = drain_sync_q[SYNC_STAGES-1] ^ drain_prev_q;

  // Rotate the doubled request vector so bit 0 is the requester just after the pointer.
  logic [2*N_REQ-1:0] req_rot;
  logic               win_vld;
  logic [IW-1:0]      win_id;

  always_comb begin
    req_rot = {i_req, i_req} >> (int'(ptr_q) + 1);
    win_vld = 1'b0;
    win_id  = '0;
    for (int j = N_REQ-1; j >= 0; j--) begin
      if (req_rot[j]) begin
        win_vld = 1'b1;
        win_id  = IW'((int'(ptr_q) + 1 + j) % N_REQ);
      end
    end
  end

  logic issue;
  logic underflow;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gnt_id_d  = gnt_id_q;
    ack_d     = '0;
    drive_d   = drive_q;
    ptr_d     = ptr_q;
    timer_d   = timer_q;
    issue     = 1'b0;
    underflow = drain_ev && (count_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (free_ev || underflow) begin
          state_d = ST_ERR;
        end else if (win_vld && (count_q < DEPTH_C)) begin
          issue    = 1'b1;
          state_d  = ST_WAIT;
          grant_d  = N_REQ'(1) << win_id;
          gnt_id_d = win_id;
          drive_d  = ~drive_q;
          timer_d  = '0;
        end
      end
      ST_WAIT: begin
        if (underflow) begin
          state_d = ST_ERR;
          grant_d = '0;
        end else if (free_ev) begin
          ack_d   = grant_q;
          grant_d = '0;
          ptr_d   = gnt_id_q;
          state_d = ST_IDLE;
        end else if (timer_q == TIMEOUT_C) begin
          state_d = ST_ERR;
          grant_d = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_ERR;
        grant_d = '0;
      end
    endcase

    // An issue and a drain landing together cancel out.
    count_d = count_q;
    if (issue && !drain_ev) begin
      count_d = count_q + CW'(1);
    end else if (drain_ev && !issue && !underflow) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gnt_id_q <= '0;
      ack_q    <= '0;
      drive_q  <= 1'b0;
      ptr_q    <= PTR_RST;
      count_q  <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gnt_id_q <= gnt_id_d;
      ack_q    <= ack_d;
      drive_q  <= drive_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
    end
  end

  assign o_grant  = grant_q;
  assign o_gnt_id = gnt_id_q;
  assign o_ack    = ack_q;
  assign o_drive  = drive_q;
  assign o_count  = count_q;
  assign o_busy   = (state_q != ST_IDLE);
  assign o_err    = (state_q == ST_ERR);

endmodule

// File: tb/tb_mem_fifo_arbiter.sv
// Bench for mem_fifo_arbiter: directed scenarios then random traffic, all checked against a
// transaction-level model that tracks in-flight writes, credits and pending toggle events.
module tb_mem_fifo_arbiter;
  localparam int N  = 4;
  localparam int D  = 3;
  localparam int S  = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_req = 4'b0;
  logic       i_free = 1'b0;
  logic       i_drain = 1'b0;
  logic [3:0] o_grant;
  logic [1:0] o_gnt_id;
  logic [3:0] o_ack;
  logic       o_drive;
  logic [1:0] o_count;
  logic       o_busy;
  logic       o_err;

  always #5 clk = ~clk;

  mem_fifo_arbiter #(.N_REQ(N), .DEPTH(D), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .o_grant(o_grant), .o_gnt_id(o_gnt_id),
    .o_ack(o_ack), .o_drive(o_drive), .i_free(i_free), .i_drain(i_drain),
    .o_count(o_count), .o_busy(o_busy), .o_err(o_err)
  );

  int tests = 0;
  int fails = 0;
  int e = 0;
  bit free_due[int];
  bit drain_due[int];

  bit         m_busy, m_err, m_drive, m_issued;
  int         m_win, m_ptr, m_count, m_t0, m_gnt_id;
  logic [3:0] m_ack;

  bit  auto_free = 0;
  bit  auto_drain = 0;
  int  free_max = 0;
  int  free_cd = -1;
  bit  drain_next = 0;
  int  dut_order[$];
  logic prev_drive = 1'b0;
  int  exp_order[5] = '{0, 1, 2, 3, 0};
  logic dv;
  int  first;
  bit  dtg;

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_drive = 0; m_issued = 0;
    m_win = 0; m_ptr = N-1; m_count = 0; m_t0 = 0; m_gnt_id = 0; m_ack = 4'b0;
    free_due.delete(); drain_due.delete();
    free_cd = -1; drain_next = 0;
  endtask

  function automatic int rr_pick(logic [3:0] req);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (m_ptr + k) % N;
      if (req[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] req, input bit fe, input bit de);
    bit uf;
    bit iss;
    uf = de && (m_count == 0);
    iss = 0;
    m_ack = 4'b0;
    if (m_err) begin
      // error is terminal until reset
    end else if (!m_busy) begin
      if (fe || uf) m_err = 1;
      else if (req != 4'b0 && m_count < D) begin
        m_win = rr_pick(req); m_gnt_id = m_win; m_busy = 1;
        m_drive = !m_drive; m_t0 = e; iss = 1;
      end
    end else begin
      if (uf) begin m_err = 1; m_busy = 0; end
      else if (fe) begin m_ack = 4'b0001 << m_win; m_busy = 0; m_ptr = m_win; end
      else if (e - m_t0 == TO + 1) begin m_err = 1; m_busy = 0; end
    end
    if (de && m_count > 0) m_count--;
    if (iss) m_count++;
    m_issued = iss;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [3:0] eg;
    eg = m_busy ? (4'b0001 << m_win) : 4'b0000;
    tests++;
    assert (o_grant === eg) else begin fails++; $error("FAIL grant e=%0d got=%b exp=%b", e, o_grant, eg); end
    tests++;
    assert (o_gnt_id === 2'(m_gnt_id)) else begin fails++; $error("FAIL gnt_id e=%0d got=%0d exp=%0d", e, o_gnt_id, m_gnt_id); end
    tests++;
    assert (o_ack === m_ack) else begin fails++; $error("FAIL ack e=%0d got=%b exp=%b", e, o_ack, m_ack); end
    tests++;
    assert (o_drive === m_drive) else begin fails++; $error("FAIL drive e=%0d got=%b exp=%b", e, o_drive, m_drive); end
    tests++;
    assert (o_count === 2'(m_count)) else begin fails++; $error("FAIL count e=%0d got=%0d exp=%0d", e, o_count, m_count); end
    tests++;
    assert (o_busy === (m_busy || m_err)) else begin fails++; $error("FAIL busy e=%0d got=%b exp=%b", e, o_busy, m_busy || m_err); end
    tests++;
    assert (o_err === m_err) else begin fails++; $error("FAIL err e=%0d got=%b exp=%b", e, o_err, m_err); end
  endtask

  // One clock: drive inputs, advance the model for the coming edge, then compare after the edge.
  task automatic cycle(input logic [3:0] req, input bit ftog, input bit dtog);
    bit ft, dt, fe, de;
    ft = ftog;
    dt = dtog;
    if (free_cd == 0) begin ft = 1; free_cd = -1; end
    else if (free_cd > 0) free_cd--;
    if (drain_next) begin dt = 1; drain_next = 0; end
    i_req = req;
    if (ft) begin i_free = ~i_free; if (!rst) free_due[e + 1 + S] = 1; end
    if (dt) begin i_drain = ~i_drain; if (!rst) drain_due[e + 1 + S] = 1; end
    @(posedge clk);
    e++;
    fe = free_due.exists(e);
    de = drain_due.exists(e);
    if (fe) free_due.delete(e);
    if (de) drain_due.delete(e);
    if (rst) model_reset();
    else model_step(req, fe, de);
    if (m_issued && auto_free) free_cd = int'($urandom_range(0, free_max));
    if (m_ack != 4'b0 && auto_drain) drain_next = 1;
    #1;
    check_outputs();
    if (o_drive !== prev_drive) dut_order.push_back(int'(o_gnt_id));
    prev_drive = o_drive;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_free = 1'b0;
    i_drain = 1'b0;
    repeat (4) cycle(4'b0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at e=%0d", e);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();

    // single request, late free
    do_reset();
    chk("rst_grant", o_grant, 4'b0);
    chk("rst_count", o_count, 0);
    cycle(4'b0001, 0, 0);
    chk("t1_drive", o_drive, 1);
    chk("t1_grant", o_grant, 4'b0001);
    repeat (4) cycle(4'b0001, 0, 0);
    cycle(4'b0001, 1, 0);
    cycle(4'b0001, 0, 0);
    chk("t1_grant_held", o_grant, 4'b0001);
    cycle(4'b0001, 0, 0);
    chk("t1_ack", o_ack, 4'b0001);
    cycle(4'b0000, 0, 0);
    chk("t1_ack_pulse", o_ack, 4'b0);
    chk("t1_count", o_count, 1);

    // all requesting: round-robin order
    do_reset();
    dut_order.delete();
    auto_free = 1; free_max = 0; auto_drain = 1;
    repeat (30) cycle(4'b1111, 0, 0);
    repeat (8) cycle(4'b0000, 0, 0);
    chk("t2_nwrites", 32'(dut_order.size() >= 5), 1);
    for (int i = 0; i < 5; i++) begin
      if (i < dut_order.size()) chk($sformatf("t2_order%0d", i), dut_order[i], exp_order[i]);
    end

    // full FIFO blocks, drain releases
    do_reset();
    auto_drain = 0; auto_free = 1; free_max = 0;
    repeat (16) cycle(4'b0001, 0, 0);
    chk("t3_full", o_count, 3);
    dv = o_drive;
    repeat (5) cycle(4'b0100, 0, 0);
    chk("t3_no_drive", o_drive, dv);
    chk("t3_no_grant", o_grant, 4'b0);
    cycle(4'b0100, 0, 1);
    cycle(4'b0100, 0, 0);
    cycle(4'b0100, 0, 0);
    chk("t3_count2", o_count, 2);
    chk("t3_not_yet", o_grant, 4'b0);
    cycle(4'b0100, 0, 0);
    chk("t3_grant", o_grant, 4'b0100);
    repeat (6) cycle(4'b0000, 0, 0);

    // drain coinciding with issue
    cycle(4'b0000, 0, 1);
    cycle(4'b0000, 0, 1);
    cycle(4'b0000, 0, 0);
    chk("t4_pre", o_count, 2);
    cycle(4'b0001, 0, 0);
    chk("t4_count", o_count, 2);
    chk("t4_err", o_err, 0);
    chk("t4_grant", o_grant, 4'b0001);
    repeat (6) cycle(4'b0000, 0, 0);

    // timeout
    do_reset();
    auto_free = 0;
    cycle(4'b0010, 0, 0);
    chk("t5_grant", o_grant, 4'b0010);
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle(4'b0000, 0, 0);
      if (o_err === 1'b1 && first == 0) first = k;
    end
    chk("t5_err_cycle", first, 17);
    chk("t5_grant0", o_grant, 4'b0);
    cycle(4'b1111, 1, 1);
    repeat (4) cycle(4'b1111, 0, 0);
    chk("t5_sticky", o_err, 1);
    chk("t5_frozen", o_drive, 1);
    do_reset();
    chk("t5_rst_err", o_err, 0);
    chk("t5_rst_drive", o_drive, 0);
    chk("t5_rst_busy", o_busy, 0);

    // underflow, then reset mid-transfer
    cycle(4'b0000, 0, 1);
    cycle(4'b0000, 0, 0);
    cycle(4'b0000, 0, 0);
    chk("t6_underflow", o_err, 1);
    chk("t6_count0", o_count, 0);
    do_reset();
    repeat (4) cycle(4'b0001, 0, 0);
    cycle(4'b0001, 1, 0);
    rst = 1'b1; i_free = 1'b0; i_drain = 1'b0;
    cycle(4'b0001, 0, 0);
    chk("t6_rst_grant", o_grant, 4'b0);
    chk("t6_rst_count", o_count, 0);
    cycle(4'b0001, 0, 0);
    chk("t6_rst_noack", o_ack, 4'b0);
    repeat (2) cycle(4'b0001, 0, 0);
    rst = 1'b0;
    repeat (3) cycle(4'b0000, 0, 0);

    // random traffic
    do_reset();
    auto_free = 1; free_max = 5; auto_drain = 0;
    repeat (400) begin
      dtg = (m_count - drain_due.num() > 0) && ($urandom_range(0, 3) == 0);
      cycle(4'($urandom_range(0, 15)), 0, dtg);
    end
    repeat (12) cycle(4'b0000, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
